// File: rtl/dma_mc_pkg.sv
// dma_mc_pkg: shared types and constants for the multi-channel DMA controller.
//   state_e      - transfer engine FSM states
//   ACC_*        - access-type encodings driven on chk_type_o
//   ERR_*        - per-channel completion codes reported on err_code_o
package dma_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHK_LD = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHK_ST = 3'd3,
    ST_STORE  = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  localparam logic [2:0] ACC_READ  = 3'b001;
  localparam logic [2:0] ACC_WRITE = 3'b010;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_LD_DENY = 2'd1;
  localparam logic [1:0] ERR_ST_DENY = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

endpackage

// File: rtl/dma_mc_if.sv
// dma_mc_if: permission-check and memory-burst bus of the DMA engine.
// Signal suffixes are from the DMA's point of view (_o driven by the DMA).
//   chk_valid_o/chk_addr_o/chk_type_o : check request, one address per cycle
//   chk_allow_i                       : combinational PMP verdict, same cycle
//   mem_req_o/mem_we_o/mem_addr_o/mem_len_o/mem_ch_o : burst request
//   mem_gnt_i/mem_done_i              : burst accepted / burst completed
// Handshake: a burst is transferred on the cycle where mem_req_o and
// mem_gnt_i are both high; request fields are stable while mem_req_o waits;
// mem_done_i may arrive in the grant cycle or any later cycle.
// Modports: master (DMA side), slave (checker/memory side).
interface dma_mc_if #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16,
  parameter int CH_W   = 2
);
  logic              chk_valid_o;
  logic [ADDR_W-1:0] chk_addr_o;
  logic [2:0]        chk_type_o;
  logic              chk_allow_i;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LEN_W-1:0]  mem_len_o;
  logic [CH_W-1:0]   mem_ch_o;
  logic              mem_gnt_i;
  logic              mem_done_i;

  modport master (
    output chk_valid_o, chk_addr_o, chk_type_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_len_o, mem_ch_o,
    input  chk_allow_i, mem_gnt_i, mem_done_i
  );

  modport slave (
    input  chk_valid_o, chk_addr_o, chk_type_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_len_o, mem_ch_o,
    output chk_allow_i, mem_gnt_i, mem_done_i
  );
endinterface

// File: rtl/dma_mc_rr_arb.sv
// dma_rr_arb: combinational round-robin arbiter.
//   req_i : request vector, one bit per channel
//   ptr_i : highest-priority channel index
//   gnt_o : lowest requesting index at or after ptr_i (wrapping)
//   any_o : at least one request present
module dma_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   gnt_o,
  output logic              any_o
);

  // Rotate so bit 0 is the channel at ptr_i, then take the first set bit.
  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;

  assign w_dbl = {req_i, req_i} >> ptr_i;
  assign w_rot = w_dbl[NUM_CH-1:0];

  always_comb begin
    logic [CH_W:0] v_sum;
    gnt_o = '0;
    any_o = 1'b0;
    v_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_o && w_rot[i]) begin
        any_o = 1'b1;
        v_sum = {1'b0, ptr_i} + (CH_W+1)'(i);
        if (v_sum >= (CH_W+1)'(NUM_CH)) v_sum = v_sum - (CH_W+1)'(NUM_CH);
        gnt_o = v_sum[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_mc.sv
// dma_mc: multi-channel PMP-checked DMA controller.
// NUM_CH descriptors share one engine, granted round-robin. Each transfer
// checks every source word (read), issues one load burst, checks every
// destination word (write), issues one store burst, then reports a code.
// Ports:
//   clk_i, rst_i               : clock, synchronous active-high reset
//   start_i/abort_i/done_clr_i : per-channel control pulses
//   cfg_len_i/cfg_src_i/cfg_dst_i : packed per-channel descriptors
//   busy_o/done_o/err_code_o   : per-channel status
//   dbg_state_o                : engine FSM state
//   bus                        : check + memory bus (dma_mc_if.master)
// Optional: DMA_MC_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on LOAD/STORE.
module dma_mc
  import dma_mc_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int ADDR_W         = 64,
  parameter int LEN_W          = 16,
  parameter int WORD_BYTES     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CH-1:0]      start_i,
  input  logic [NUM_CH-1:0]      abort_i,
  input  logic [NUM_CH-1:0]      done_clr_i,
  input  logic [NUM_CH*LEN_W-1:0]  cfg_len_i,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_src_i,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_dst_i,
  output logic [NUM_CH-1:0]      busy_o,
  output logic [NUM_CH-1:0]      done_o,
  output logic [NUM_CH*2-1:0]    err_code_o,
  output state_e                 dbg_state_o,
  dma_mc_if.master               bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WB_SH = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(WORD_BYTES - 1));

  state_e            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_cur, w_cur_nxt;
  logic [CH_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [LEN_W-1:0]  r_idx, w_idx_nxt;
  logic [1:0]        r_err_cur, w_err_nxt;
  logic              r_gnt_seen, w_gnt_seen_nxt;
  logic              r_abort_req, w_abort_nxt;
  logic              w_fin;

  logic [LEN_W-1:0]  r_len [NUM_CH];
  logic [ADDR_W-1:0] r_src [NUM_CH];
  logic [ADDR_W-1:0] r_dst [NUM_CH];
  logic [NUM_CH-1:0] r_busy, r_done;
  logic [NUM_CH*2-1:0] r_err;

  logic [NUM_CH-1:0] w_req, w_act_mask;
  logic [CH_W-1:0]   w_gnt;
  logic              w_any, w_abort_cur, w_mem_st;
  logic [LEN_W-1:0]  w_cur_len;
  logic [ADDR_W-1:0] w_cur_src, w_cur_dst;

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_code_o  = r_err;
  assign dbg_state_o = r_state;

  assign w_cur_len = r_len[r_cur];
  assign w_cur_src = r_src[r_cur];
  assign w_cur_dst = r_dst[r_cur];

  // Channel owned by the engine (any state but IDLE).
  always_comb begin
    w_act_mask = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_act_mask[i] = (r_state != ST_IDLE) && (r_cur == CH_W'(i));
  end

  assign w_abort_cur = |(abort_i & w_act_mask);
  // A pending channel aborted this cycle must not be granted this cycle.
  assign w_req = r_busy & ~abort_i;

  dma_rr_arb #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req_i (w_req),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_gnt),
    .any_o (w_any)
  );

`ifdef DMA_MC_TIMEOUT_EN
  logic [31:0] r_tmo;
  logic        w_tmo_hit;
  assign w_tmo_hit = (r_tmo == 32'(TIMEOUT_CYCLES - 1));

  // Restarts on every state change, so it is zero on the first LOAD/STORE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || (w_state_nxt != r_state)) r_tmo <= '0;
    else if (w_mem_st)                     r_tmo <= r_tmo + 32'd1;
  end
`else
  logic        w_tmo_hit;
  logic [31:0] w_unused_tmo;
  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

  assign w_mem_st = (r_state == ST_LOAD) || (r_state == ST_STORE);

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_nxt      = r_cur;
    w_rr_nxt       = r_rr_ptr;
    w_idx_nxt      = r_idx;
    w_err_nxt      = r_err_cur;
    w_gnt_seen_nxt = r_gnt_seen;
    w_abort_nxt    = r_abort_req;
    w_fin          = 1'b0;
    bus.chk_valid_o = 1'b0;
    bus.chk_addr_o  = '0;
    bus.chk_type_o  = ACC_READ;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_len_o   = '0;
    bus.mem_ch_o    = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_cur_nxt   = w_gnt;
          w_idx_nxt   = r_len[w_gnt] - LEN_W'(1);
          w_rr_nxt    = (w_gnt == CH_W'(NUM_CH - 1)) ? '0 : w_gnt + CH_W'(1);
          w_err_nxt   = ERR_OK;
          w_abort_nxt = 1'b0;
          w_state_nxt = ST_CHK_LD;
        end
      end

      ST_CHK_LD, ST_CHK_ST: begin
        if (w_cur_len == '0) begin
          // Zero-length descriptor: no checks, no bursts.
          w_err_nxt   = ERR_OK;
          w_state_nxt = ST_FIN;
        end else begin
          bus.chk_valid_o = 1'b1;
          bus.chk_type_o  = (r_state == ST_CHK_ST) ? ACC_WRITE : ACC_READ;
          bus.chk_addr_o  = ((r_state == ST_CHK_ST) ? w_cur_dst : w_cur_src)
                            + (ADDR_W'(r_idx) << WB_SH);
          if (w_abort_cur) begin
            w_err_nxt   = ERR_ABORT;
            w_state_nxt = ST_FIN;
          end else if (!bus.chk_allow_i) begin
            w_err_nxt   = (r_state == ST_CHK_ST) ? ERR_ST_DENY : ERR_LD_DENY;
            w_state_nxt = ST_FIN;
          end else if (r_idx == '0) begin
            w_gnt_seen_nxt = 1'b0;
            w_state_nxt    = (r_state == ST_CHK_ST) ? ST_STORE : ST_LOAD;
          end else begin
            w_idx_nxt = r_idx - LEN_W'(1);
          end
        end
      end

      ST_LOAD, ST_STORE: begin
        bus.mem_req_o  = !r_gnt_seen;
        bus.mem_we_o   = (r_state == ST_STORE);
        bus.mem_addr_o = (r_state == ST_STORE) ? w_cur_dst : w_cur_src;
        bus.mem_len_o  = w_cur_len;
        bus.mem_ch_o   = r_cur;
        if (bus.mem_gnt_i) w_gnt_seen_nxt = 1'b1;
        // An abort here is remembered and honoured once the burst completes.
        if (w_abort_cur) w_abort_nxt = 1'b1;
        if ((r_gnt_seen || bus.mem_gnt_i) && bus.mem_done_i) begin
          if (r_abort_req || w_abort_cur) begin
            w_err_nxt   = ERR_ABORT;
            w_state_nxt = ST_FIN;
          end else if (r_state == ST_LOAD) begin
            w_idx_nxt   = w_cur_len - LEN_W'(1);
            w_state_nxt = ST_CHK_ST;
          end else begin
            w_state_nxt = ST_FIN;
          end
        end else if (w_tmo_hit) begin
          w_err_nxt   = ERR_ABORT;
          w_state_nxt = ST_FIN;
        end
      end

      ST_FIN: begin
        w_fin       = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_rr_ptr    <= '0;
      r_idx       <= '0;
      r_err_cur   <= ERR_OK;
      r_gnt_seen  <= 1'b0;
      r_abort_req <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_idx       <= w_idx_nxt;
      r_err_cur   <= w_err_nxt;
      r_gnt_seen  <= w_gnt_seen_nxt;
      r_abort_req <= w_abort_nxt;
    end
  end

  // Per-channel descriptor and status. Start beats done_clr and abort on an
  // idle channel; completion and pending-abort only apply while busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
      r_done <= '0;
      r_err  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (start_i[c] && !r_busy[c]) begin
          r_len[c]       <= cfg_len_i[c*LEN_W +: LEN_W];
          r_src[c]       <= cfg_src_i[c*ADDR_W +: ADDR_W] & ALIGN_MASK;
          r_dst[c]       <= cfg_dst_i[c*ADDR_W +: ADDR_W] & ALIGN_MASK;
          r_busy[c]      <= 1'b1;
          r_done[c]      <= 1'b0;
          r_err[c*2 +: 2] <= ERR_OK;
        end else if (r_busy[c]) begin
          if (w_fin && w_act_mask[c]) begin
            r_busy[c]      <= 1'b0;
            r_done[c]      <= 1'b1;
            r_err[c*2 +: 2] <= r_err_cur;
          end else if (abort_i[c] && !w_act_mask[c]) begin
            r_busy[c]      <= 1'b0;
            r_done[c]      <= 1'b1;
            r_err[c*2 +: 2] <= ERR_ABORT;
          end
        end else if (done_clr_i[c]) begin
          r_done[c]      <= 1'b0;
          r_err[c*2 +: 2] <= ERR_OK;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_mc.sv
// tb_dma_mc: directed self-checking bench for dma_mc.
// A combinational PMP model denies one programmable address; a memory
// responder grants each request and completes it after mem_lat cycles.
// Check and burst traffic is logged and compared with hand-built queues.
module tb_dma_mc;
  import dma_mc_pkg::*;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 16;
  localparam int CH_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH-1:0] start_i = '0, abort_i = '0, done_clr_i = '0;
  logic [NUM_CH*LEN_W-1:0]  cfg_len = '0;
  logic [NUM_CH*ADDR_W-1:0] cfg_src = '0, cfg_dst = '0;
  logic [NUM_CH-1:0]   busy_o, done_o;
  logic [NUM_CH*2-1:0] err_code_o;
  state_e              dbg_state_o;

  dma_mc_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CH_W(CH_W)) bus ();

  dma_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .WORD_BYTES(8),
           .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .abort_i(abort_i),
    .done_clr_i(done_clr_i), .cfg_len_i(cfg_len), .cfg_src_i(cfg_src),
    .cfg_dst_i(cfg_dst), .busy_o(busy_o), .done_o(done_o),
    .err_code_o(err_code_o), .dbg_state_o(dbg_state_o), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- PMP and memory models ----------------
  logic              deny_en = 1'b0;
  logic [ADDR_W-1:0] deny_addr = '0;
  assign bus.chk_allow_i = !(deny_en && (bus.chk_addr_o == deny_addr));

  logic mem_auto = 1'b1;
  int   mem_lat  = 1;
  int   req_cycles = 0;
  logic [66:0] chk_log[$];     // {type, addr}
  logic [82:0] burst_log[$];   // {we, ch, len, addr}
  logic [66:0] chk_exp_q[$];
  logic [82:0] burst_exp_q[$];

  initial begin
    bus.mem_gnt_i  = 1'b0;
    bus.mem_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_auto && !rst && bus.mem_req_o) begin
        burst_log.push_back({bus.mem_we_o, bus.mem_ch_o, bus.mem_len_o, bus.mem_addr_o});
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus.mem_gnt_i = 1'b0;
        repeat (mem_lat) @(negedge clk);
        bus.mem_done_i = 1'b1;
        @(negedge clk);
        bus.mem_done_i = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.chk_valid_o) chk_log.push_back({bus.chk_type_o, bus.chk_addr_o});
      if (bus.mem_req_o) req_cycles++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_logs(input string tag);
    check({tag, "_nchk"}, 128'(chk_log.size()), 128'(chk_exp_q.size()));
    for (int i = 0; i < chk_exp_q.size() && i < chk_log.size(); i++)
      check($sformatf("%s_chk%0d", tag, i), 128'(chk_log[i]), 128'(chk_exp_q[i]));
    check({tag, "_nburst"}, 128'(burst_log.size()), 128'(burst_exp_q.size()));
    for (int i = 0; i < burst_exp_q.size() && i < burst_log.size(); i++)
      check($sformatf("%s_burst%0d", tag, i), 128'(burst_log[i]), 128'(burst_exp_q[i]));
    chk_log.delete(); burst_log.delete(); chk_exp_q.delete(); burst_exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    chk_log.delete(); burst_log.delete(); req_cycles = 0;
  endtask

  task automatic program_ch(input int c, input logic [LEN_W-1:0] len,
                            input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst);
    cfg_len[c*LEN_W +: LEN_W]   = len;
    cfg_src[c*ADDR_W +: ADDR_W] = src;
    cfg_dst[c*ADDR_W +: ADDR_W] = dst;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    start_i = m; cyc(1); start_i = '0;
  endtask

  task automatic pulse_abort(input logic [NUM_CH-1:0] m);
    abort_i = m; cyc(1); abort_i = '0;
  endtask

  task automatic pulse_clr(input logic [NUM_CH-1:0] m);
    done_clr_i = m; cyc(1); done_clr_i = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o != '0 && n < budget) begin cyc(1); n++; end
    check(tag, 128'(busy_o), 128'(0));
  endtask

  function automatic logic [66:0] ce(input logic [2:0] t, input logic [ADDR_W-1:0] a);
    return {t, a};
  endfunction

  function automatic logic [82:0] be(input logic we, input logic [CH_W-1:0] ch,
                                     input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] a);
    return {we, ch, len, a};
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int n;
    do_reset();

    // Reset state
    check("rst_busy",  128'(busy_o), 128'(0));
    check("rst_done",  128'(done_o), 128'(0));
    check("rst_err",   128'(err_code_o), 128'(0));
    check("rst_state", 128'(dbg_state_o), 128'(ST_IDLE));
    check("rst_chk",   128'({bus.chk_valid_o, bus.chk_type_o, bus.chk_addr_o}), 128'({1'b0, 3'b001, 64'h0}));
    check("rst_mem",   128'({bus.mem_req_o, bus.mem_we_o, bus.mem_ch_o, bus.mem_len_o, bus.mem_addr_o}), 128'(0));

    // T1: ch0 len 3, all allowed
    mem_lat = 2;
    program_ch(0, 16'd3, 64'h1000, 64'h2000);
    pulse_start(4'b0001);
    wait_idle("t1_idle", 200);
    chk_exp_q = '{ce(3'b001, 64'h1010), ce(3'b001, 64'h1008), ce(3'b001, 64'h1000),
                  ce(3'b010, 64'h2010), ce(3'b010, 64'h2008), ce(3'b010, 64'h2000)};
    burst_exp_q = '{be(1'b0, 2'd0, 16'd3, 64'h1000), be(1'b1, 2'd0, 16'd3, 64'h2000)};
    cmp_logs("t1");
    check("t1_done", 128'(done_o), 128'(4'b0001));
    check("t1_err",  128'(err_code_o), 128'(0));
    pulse_clr(4'b0001);
    check("t1_clr_done", 128'(done_o), 128'(0));

    // T2: ch1 unaligned src, deny at 0x1000
    deny_en = 1'b1; deny_addr = 64'h1000;
    program_ch(1, 16'd2, 64'h1007, 64'h9000);
    pulse_start(4'b0010);
    wait_idle("t2_idle", 200);
    chk_exp_q = '{ce(3'b001, 64'h1008), ce(3'b001, 64'h1000)};
    cmp_logs("t2");
    check("t2_done", 128'(done_o), 128'(4'b0010));
    check("t2_err",  128'(err_code_o), 128'(8'b0000_0100));
    pulse_clr(4'b0010);
    check("t2_clr", 128'({done_o, err_code_o}), 128'(0));
    deny_en = 1'b0;

    // T3: round-robin from pointer 0, ch0 restarted while ch2 is served
    do_reset();
    mem_lat = 1;
    for (int c = 0; c < NUM_CH; c++)
      program_ch(c, 16'd1, 64'h1000 + 64'(c) * 64'h100, 64'h2000 + 64'(c) * 64'h100);
    pulse_start(4'b1111);
    n = 0;
    while (busy_o[1] && n < 200) begin cyc(1); n++; end
    check("t3_wait_ch1", 128'(busy_o[1]), 128'(0));
    pulse_start(4'b0001);
    wait_idle("t3_idle", 300);
    burst_exp_q = '{be(1'b0, 2'd0, 16'd1, 64'h1000), be(1'b1, 2'd0, 16'd1, 64'h2000),
                    be(1'b0, 2'd1, 16'd1, 64'h1100), be(1'b1, 2'd1, 16'd1, 64'h2100),
                    be(1'b0, 2'd2, 16'd1, 64'h1200), be(1'b1, 2'd2, 16'd1, 64'h2200),
                    be(1'b0, 2'd3, 16'd1, 64'h1300), be(1'b1, 2'd3, 16'd1, 64'h2300),
                    be(1'b0, 2'd0, 16'd1, 64'h1000), be(1'b1, 2'd0, 16'd1, 64'h2000)};
    chk_log.delete();
    chk_exp_q.delete();
    cmp_logs("t3");
    check("t3_done", 128'(done_o), 128'(4'b1111));
    check("t3_err",  128'(err_code_o), 128'(0));

    // T4: abort ch2 in LOAD and pending ch3 (pointer is at 1 -> ch2 first)
    mem_lat = 6;
    program_ch(2, 16'd2, 64'h3000, 64'h4000);
    program_ch(3, 16'd1, 64'h5000, 64'h6000);
    pulse_start(4'b1100);
    n = 0;
    while (burst_log.size() == 0 && n < 200) begin cyc(1); n++; end
    check("t4_load_seen", 128'(burst_log.size()), 128'(1));
    cyc(1);
    pulse_abort(4'b1100);
    check("t4_busy_after_abort", 128'(busy_o), 128'(4'b0100));
    check("t4_ch3_err", 128'(err_code_o[7:6]), 128'(2'd3));
    wait_idle("t4_idle", 200);
    chk_exp_q = '{ce(3'b001, 64'h3008), ce(3'b001, 64'h3000)};
    burst_exp_q = '{be(1'b0, 2'd2, 16'd2, 64'h3000)};
    cmp_logs("t4");
    check("t4_done", 128'(done_o[3:2]), 128'(2'b11));
    check("t4_err",  128'(err_code_o[7:4]), 128'(4'hF));

    // T5: zero-length on ch0
    mem_lat = 1;
    program_ch(0, 16'd0, 64'hA000, 64'hB000);
    req_cycles = 0;
    pulse_start(4'b0001);
    n = 0;
    while (!done_o[0] && n < 3) begin cyc(1); n++; end
    check("t5_done", 128'(done_o[0]), 128'(1));
    check("t5_err",  128'(err_code_o[1:0]), 128'(0));
    check("t5_busy", 128'(busy_o), 128'(0));
    check("t5_req_cycles", 128'(req_cycles), 128'(0));
    cmp_logs("t5");

`ifdef DMA_MC_TIMEOUT_EN
    // T6: memory never grants; watchdog fires after 16 request cycles
    mem_auto = 1'b0;
    program_ch(1, 16'd1, 64'hC000, 64'hD000);
    req_cycles = 0;
    pulse_start(4'b0010);
    wait_idle("t6_idle", 200);
    check("t6_req_cycles", 128'(req_cycles), 128'(16));
    check("t6_done", 128'(done_o[1]), 128'(1));
    check("t6_err",  128'(err_code_o[3:2]), 128'(2'd3));
    chk_log.delete();
    mem_auto = 1'b1;
`endif

    // T7: reset while checking the destination
    mem_lat = 0;
    program_ch(0, 16'd4, 64'h7000, 64'h8000);
    pulse_start(4'b0001);
    n = 0;
    while ((chk_log.size() == 0 || chk_log[chk_log.size()-1][66:64] != 3'b010) && n < 200) begin
      cyc(1); n++;
    end
    check("t7_in_chk_st", 128'(dbg_state_o), 128'(ST_CHK_ST));
    rst = 1'b1;
    cyc(1);
    check("t7_status", 128'({busy_o, done_o, err_code_o}), 128'(0));
    check("t7_state",  128'(dbg_state_o), 128'(ST_IDLE));
    check("t7_chk",    128'({bus.chk_valid_o, bus.chk_type_o, bus.chk_addr_o}), 128'({1'b0, 3'b001, 64'h0}));
    check("t7_mem",    128'({bus.mem_req_o, bus.mem_we_o, bus.mem_ch_o, bus.mem_len_o, bus.mem_addr_o}), 128'(0));
    rst = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
